// File: rtl/mul_int_seq_ctrl_pkg.sv
// mul_int_seq_ctrl_pkg: shared sequencer state encodings and handshake helper
package mul_int_seq_ctrl_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   function automatic logic fire(input logic v, input logic r);
      return v && r;
   endfunction
endpackage

// File: rtl/mul_int_seq_ctrl_adder.sv
// mul_int_seq_ctrl_adder: WIDTH-bit adder for the accumulate step (carry-out dropped)
// ports: a, b addends; sum = (a + b) mod 2^WIDTH
module mul_int_seq_ctrl_adder #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);
   assign sum = a + b;
endmodule

// File: rtl/mul_int_seq_ctrl.sv
// mul_int_seq_ctrl: shift-and-add multiply sequencer, P = lower WIDTH bits of A*B after WIDTH steps
// ports: clk, rst (sync, active-high); in_valid/in_ready with operands A, B;
//        out_valid/out_ready with registered product P; busy high outside IDLE
module mul_int_seq_ctrl
   import mul_int_seq_ctrl_pkg::*;
#(parameter int WIDTH = 8) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] P,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   logic [1:0]       state;
   logic [WIDTH-1:0] acc, mcand, mplier, sum;
   logic [CNT_W-1:0] cnt;
   mul_int_seq_ctrl_adder #(.WIDTH(WIDTH)) u_add (
      .a(acc),
      .b(mplier[0] ? mcand : '0),
      .sum(sum)
   );
   assign in_ready  = state == ST_IDLE;
   assign out_valid = state == ST_DONE;
   assign busy      = state != ST_IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         P      <= '0;
      end else begin
         case (state)
            ST_IDLE: if (fire(in_valid, in_ready)) begin
               mcand  <= A;
               mplier <= B;
               acc    <= '0;
               cnt    <= '0;
               state  <= ST_RUN;
            end
            ST_RUN: begin
               acc    <= sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               // fixed WIDTH steps, no early exit, so latency is data-independent
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  P     <= sum;
                  state <= ST_DONE;
               end
            end
            ST_DONE: if (fire(out_valid, out_ready)) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_int_seq_ctrl.sv
// tb_mul_int_seq_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 multiply sequencers
module tb_mul_int_seq_ctrl;
   typedef struct {
      logic [7:0] p;
      int         t;
   } exp_t;
   logic clk = 0, rst = 1;
   logic v8 = 0, or8 = 1, rdy8, ov8, busy8;
   logic [7:0] a8 = 0, b8 = 0, p8;
   logic v1 = 0, or1 = 1, rdy1, ov1, busy1;
   logic [0:0] a1 = 0, b1 = 0, p1;
   int cyc = 0, vectors = 0, miscompares = 0;
   exp_t q8[$], q1[$];
   logic ov8_q = 0, ov1_q = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   mul_int_seq_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .A(a8), .B(b8),
      .out_valid(ov8), .out_ready(or8), .P(p8), .busy(busy8)
   );
   mul_int_seq_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .A(a1), .B(b1),
      .out_valid(ov1), .out_ready(or1), .P(p1), .busy(busy1)
   );
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // monitors: pop on the first cycle of each completion, check product and latency
   always @(negedge clk) begin
      exp_t e;
      if (ov8 && !ov8_q) begin
         if (q8.size() == 0) chk("w8_unexpected_completion", 1, 0);
         else begin
            e = q8.pop_front();
            chk("w8_product", int'(p8), int'(e.p));
            chk("w8_latency", cyc - e.t, 8);
         end
      end
      ov8_q = ov8;
   end
   always @(negedge clk) begin
      exp_t e;
      if (ov1 && !ov1_q) begin
         if (q1.size() == 0) chk("w1_unexpected_completion", 1, 0);
         else begin
            e = q1.pop_front();
            chk("w1_product", int'(p1), int'(e.p[0]));
            chk("w1_latency", cyc - e.t, 1);
         end
      end
      ov1_q = ov1;
   end
   task automatic job8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
      int n = 0;
      @(negedge clk);
      while (!rdy8 && n < 100) begin @(negedge clk); n++; end
      if (n == 100) chk("w8_accept_timeout", 1, 0);
      a8 = a; b8 = b; v8 = 1;
      q8.push_back('{p: exp, t: cyc + 1});
      @(negedge clk);
      v8 = 0;
   endtask
   task automatic job1(input logic a, input logic b, input logic exp);
      int n = 0;
      @(negedge clk);
      while (!rdy1 && n < 100) begin @(negedge clk); n++; end
      if (n == 100) chk("w1_accept_timeout", 1, 0);
      a1 = a; b1 = b; v1 = 1;
      q1.push_back('{p: {7'd0, exp}, t: cyc + 1});
      @(negedge clk);
      v1 = 0;
   endtask
   task automatic wait_ov8();
      int n = 0;
      while (!ov8 && n < 100) begin @(negedge clk); n++; end
      if (n == 100) chk("w8_done_timeout", 1, 0);
   endtask
   task automatic drain();
      int n = 0;
      while ((q8.size() != 0 || q1.size() != 0 || busy8 || busy1) && n < 200) begin @(negedge clk); n++; end
      if (n == 200) chk("drain_timeout", 1, 0);
   endtask
   initial begin
      logic [7:0] ra, rb;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_in_ready", int'(rdy8), 1);
      chk("rst_out_valid", int'(ov8), 0);
      chk("rst_busy", int'(busy8), 0);
      chk("rst_p", int'(p8), 0);
      chk("rst_w1_in_ready", int'(rdy1), 1);
      job8(8'd3, 8'd5, 8'd15);
      wait_ov8();
      @(negedge clk);
      chk("t1_in_ready_after", int'(rdy8), 1);
      job8(8'd200, 8'd3, 8'd88);
      job8(8'hFF, 8'hFF, 8'h01);
      job8(8'h00, 8'hAB, 8'h00);
      drain();
      or8 = 0;
      job8(8'd7, 8'd9, 8'd63);
      wait_ov8();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", int'(ov8), 1);
         chk("bp_p", int'(p8), 63);
         chk("bp_in_ready", int'(rdy8), 0);
         chk("bp_busy", int'(busy8), 1);
         v8 = i[0]; a8 = 8'd99; b8 = 8'd77;
      end
      v8 = 0;
      or8 = 1;
      @(negedge clk);
      chk("bp_release_out_valid", int'(ov8), 0);
      chk("bp_release_in_ready", int'(rdy8), 1);
      job8(8'h12, 8'h34, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      q8.delete();
      chk("mid_rst_out_valid", int'(ov8), 0);
      chk("mid_rst_p", int'(p8), 0);
      chk("mid_rst_in_ready", int'(rdy8), 1);
      rst = 0;
      repeat (12) @(negedge clk);
      job8(8'd6, 8'd7, 8'd42);
      drain();
      job8(8'd10, 8'd11, 8'd110);
      for (int i = 0; i < 8; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
      end
      drain();
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         job8(ra, rb, 8'(16'(ra) * 16'(rb)));
      end
      drain();
      job1(1'b1, 1'b1, 1'b1);
      job1(1'b1, 1'b0, 1'b0);
      job1(1'b0, 1'b1, 1'b0);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
